// File: rtl/ex_mem_pipe_reg_pkg.sv
// pipe_pkg: shared EX/MEM pipeline control type, bubble constant and depth limit
package pipe_pkg;
  localparam int MAX_PIPE_STAGES = 4;
  typedef struct packed {
    logic MemRead;
    logic MemToReg;
    logic MemWrite;
    logic RegWrite;
    logic Valid;
  } ex_mem_ctrl_t;
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  function automatic int ex_mem_data_w(input int data_w, input int reg_aw);
    return 2 * data_w + reg_aw;
  endfunction
endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_if: E-side inputs and M-side outputs of ex_mem_pipe_reg
// EXMEM_PERF_CNT_EN adds CntClr, StallCnt and BubbleCnt
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 1
);
  logic StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE;
  logic [DATA_W-1:0] ALUresultE, ReadData2E;
  logic [REG_AW-1:0] WriteRegE;
  logic ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM;
  logic [DATA_W-1:0] ALUresultM, ReadData2M;
  logic [REG_AW-1:0] WriteRegM;
  logic [STAGES-1:0] FwdRegWrite;
  logic [STAGES*REG_AW-1:0] FwdWriteReg;
`ifdef EXMEM_PERF_CNT_EN
  logic CntClr;
  logic [31:0] StallCnt, BubbleCnt;
  modport master (
    output StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
           ALUresultE, ReadData2E, WriteRegE, CntClr,
    input  ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM, ALUresultM, ReadData2M,
           WriteRegM, FwdRegWrite, FwdWriteReg, StallCnt, BubbleCnt
  );
  modport slave (
    input  StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
           ALUresultE, ReadData2E, WriteRegE, CntClr,
    output ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM, ALUresultM, ReadData2M,
           WriteRegM, FwdRegWrite, FwdWriteReg, StallCnt, BubbleCnt
  );
`else
  modport master (
    output StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
           ALUresultE, ReadData2E, WriteRegE,
    input  ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM, ALUresultM, ReadData2M,
           WriteRegM, FwdRegWrite, FwdWriteReg
  );
  modport slave (
    input  StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
           ALUresultE, ReadData2E, WriteRegE,
    output ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM, ALUresultM, ReadData2M,
           WriteRegM, FwdRegWrite, FwdWriteReg
  );
`endif
endinterface

// File: rtl/ex_mem_pipe_reg_stage.sv
// pipe_stage: one EX/MEM register stage; bubble beats hold beats load, control zeroed for invalid entries
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DW = 69
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         hold_i,
  input  logic         load_bubble_i,
  input  ex_mem_ctrl_t ctrl_i,
  input  logic [DW-1:0] data_i,
  output ex_mem_ctrl_t ctrl_o,
  output logic [DW-1:0] data_o
);
  ex_mem_ctrl_t ctrl_d, ctrl_q;
  logic [DW-1:0] data_d, data_q;
  always_comb begin
    ctrl_d = load_bubble_i ? EX_MEM_BUBBLE : hold_i ? ctrl_q : ctrl_i.Valid ? ctrl_i : EX_MEM_BUBBLE;
    data_d = load_bubble_i ? '0 : hold_i ? data_q : data_i;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      ctrl_q <= EX_MEM_BUBBLE;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: STAGES-deep EX/MEM pipeline register with stall, flush and forwarding taps
// EXMEM_PERF_CNT_EN adds saturating StallCnt/BubbleCnt counters cleared by CntClr
module ex_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 1
) (
  input logic   Clk,
  input logic   Rst_n,
  ex_mem_if.slave bus
);
  typedef struct packed {
    logic [DATA_W-1:0] ALUresult;
    logic [DATA_W-1:0] ReadData2;
    logic [REG_AW-1:0] WriteReg;
  } ex_mem_data_t;
  localparam int DW = ex_mem_data_w(DATA_W, REG_AW);
  if (STAGES < 1 || STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $error("ex_mem_pipe_reg: STAGES must be in 1..%0d", MAX_PIPE_STAGES);
  end
  // index 0 is the E-side input, index k+1 is the output of stage k
  ex_mem_ctrl_t ctrl_s [STAGES+1];
  ex_mem_data_t data_s [STAGES+1];
  logic [STAGES-1:0] fwd_rw;
  logic [STAGES*REG_AW-1:0] fwd_wr;
  assign ctrl_s[0] = {bus.MemReadE, bus.MemToRegE, bus.MemWriteE, bus.RegWriteE, bus.ValidE};
  assign data_s[0] = {bus.ALUresultE, bus.ReadData2E, bus.WriteRegE};
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_stage #(.DW(DW)) u_stage (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .hold_i       (bus.StallE),
      .load_bubble_i(k == 0 && bus.FlushE),
      .ctrl_i       (ctrl_s[k]),
      .data_i       (data_s[k]),
      .ctrl_o       (ctrl_s[k+1]),
      .data_o       (data_s[k+1])
    );
    assign fwd_rw[k] = ctrl_s[k+1].RegWrite & ctrl_s[k+1].Valid;
    assign fwd_wr[k*REG_AW +: REG_AW] = data_s[k+1].WriteReg;
  end
  assign bus.ValidM      = ctrl_s[STAGES].Valid;
  assign bus.MemReadM    = ctrl_s[STAGES].MemRead;
  assign bus.MemToRegM   = ctrl_s[STAGES].MemToReg;
  assign bus.MemWriteM   = ctrl_s[STAGES].MemWrite;
  assign bus.RegWriteM   = ctrl_s[STAGES].RegWrite;
  assign bus.ALUresultM  = data_s[STAGES].ALUresult;
  assign bus.ReadData2M  = data_s[STAGES].ReadData2;
  assign bus.WriteRegM   = data_s[STAGES].WriteReg;
  assign bus.FwdRegWrite = fwd_rw;
  assign bus.FwdWriteReg = fwd_wr;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  always_comb begin
    stall_cnt_d  = bus.CntClr ? '0 : (bus.StallE && ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    bubble_cnt_d = bus.CntClr ? '0 : (!bus.StallE && !ctrl_s[STAGES].Valid && ~&bubble_cnt_q)
                   ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  assign bus.StallCnt  = stall_cnt_q;
  assign bus.BubbleCnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: drives ex_mem_pipe_reg at STAGES=1..4 in parallel against a stage-array model
module tb_ex_mem_pipe_reg;
  typedef struct packed {
    logic v, mr, mtr, mw, rw;
    logic [31:0] alu, rd2;
    logic [4:0] wr;
  } rec_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b1;
  logic StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE;
  logic [31:0] ALUresultE, ReadData2E;
  logic [4:0] WriteRegE;
  rec_t obs [4];
  logic [3:0] obs_frw [4];
  logic [19:0] obs_fwr [4];
  rec_t mdl [4][4];
  int checks = 0;
  int errors = 0;
`ifdef EXMEM_PERF_CNT_EN
  logic CntClr = 1'b0;
  logic [31:0] obs_sc [4], obs_bc [4];
  logic [31:0] m_sc;
  logic [31:0] m_bc [4];
`endif

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 4; g++) begin : gd
    ex_mem_if #(.DATA_W(32), .REG_AW(5), .STAGES(g + 1)) bus ();
    assign bus.StallE     = StallE;
    assign bus.FlushE     = FlushE;
    assign bus.ValidE     = ValidE;
    assign bus.MemReadE   = MemReadE;
    assign bus.MemToRegE  = MemToRegE;
    assign bus.MemWriteE  = MemWriteE;
    assign bus.RegWriteE  = RegWriteE;
    assign bus.ALUresultE = ALUresultE;
    assign bus.ReadData2E = ReadData2E;
    assign bus.WriteRegE  = WriteRegE;
    ex_mem_pipe_reg #(.DATA_W(32), .REG_AW(5), .STAGES(g + 1)) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .bus  (bus)
    );
    assign obs[g] = {bus.ValidM, bus.MemReadM, bus.MemToRegM, bus.MemWriteM, bus.RegWriteM,
                     bus.ALUresultM, bus.ReadData2M, bus.WriteRegM};
    assign obs_frw[g] = 4'(bus.FwdRegWrite);
    assign obs_fwr[g] = 20'(bus.FwdWriteReg);
`ifdef EXMEM_PERF_CNT_EN
    assign bus.CntClr = CntClr;
    assign obs_sc[g] = bus.StallCnt;
    assign obs_bc[g] = bus.BubbleCnt;
`endif
  end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 4; k++) mdl[d][k] = rec_t'(0);
`ifdef EXMEM_PERF_CNT_EN
    m_sc = 0;
    for (int d = 0; d < 4; d++) m_bc[d] = 0;
`endif
  endtask

  // one clock edge of an ideal pipeline: bubble in front on flush, freeze on stall, else shift
  task automatic model_edge();
    rec_t inp;
    rec_t old [4];
    if (!Rst_n) begin
      clear_model();
      return;
    end
    inp = {ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE, ALUresultE, ReadData2E, WriteRegE};
    if (!inp.v) {inp.mr, inp.mtr, inp.mw, inp.rw} = 4'b0;
`ifdef EXMEM_PERF_CNT_EN
    if (CntClr) begin
      m_sc = 0;
      for (int d = 0; d < 4; d++) m_bc[d] = 0;
    end else begin
      if (StallE && m_sc != 32'hFFFF_FFFF) m_sc++;
      for (int d = 0; d < 4; d++)
        if (!StallE && !mdl[d][d].v && m_bc[d] != 32'hFFFF_FFFF) m_bc[d]++;
    end
`endif
    for (int d = 0; d < 4; d++) begin
      old = mdl[d];
      for (int k = 0; k <= d; k++) begin
        if (k == 0) begin
          if (FlushE) mdl[d][0] = rec_t'(0);
          else if (!StallE) mdl[d][0] = inp;
        end else if (!StallE) mdl[d][k] = old[k-1];
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [3:0] erw;
    logic [19:0] ewr;
    for (int d = 0; d < 4; d++) begin
      erw = '0;
      ewr = '0;
      for (int k = 0; k <= d; k++) begin
        erw[k] = mdl[d][k].rw & mdl[d][k].v;
        ewr[k*5 +: 5] = mdl[d][k].wr;
      end
      chk($sformatf("%s_s%0d_out", ph, d + 1), 128'(obs[d]), 128'(mdl[d][d]));
      chk($sformatf("%s_s%0d_fwd", ph, d + 1), 128'({obs_frw[d], obs_fwr[d]}), 128'({erw, ewr}));
`ifdef EXMEM_PERF_CNT_EN
      chk($sformatf("%s_s%0d_stallcnt", ph, d + 1), 128'(obs_sc[d]), 128'(m_sc));
      chk($sformatf("%s_s%0d_bubblecnt", ph, d + 1), 128'(obs_bc[d]), 128'(m_bc[d]));
`endif
    end
  endtask

  task automatic step(input logic st, input logic fl, input logic v, input logic mr, input logic mtr,
                      input logic mw, input logic rw, input logic [31:0] alu, input logic [31:0] rd2,
                      input logic [4:0] wr, input string ph);
    {StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE} = {st, fl, v, mr, mtr, mw, rw};
    ALUresultE = alu;
    ReadData2E = rd2;
    WriteRegE  = wr;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check_all(ph);
  endtask

  task automatic rand_step(input logic st, input logic fl, input string ph);
    step(st, fl, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         $urandom, $urandom, 5'($urandom), ph);
  endtask

  initial begin
    {StallE, FlushE, ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE} = '0;
    ALUresultE = '0;
    ReadData2E = '0;
    WriteRegE  = '0;
    #2 Rst_n = 1'b0;
    #1 clear_model();
    check_all("rst_async");
    @(negedge Clk);
    for (int i = 0; i < 3; i++) rand_step(1'($urandom), 1'($urandom), "rst_held");
    Rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "release");
    step(0, 0, 1, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 5'd9, "dbeef");
    chk("dbeef_alu", 128'(obs[0].alu), 128'(32'hDEAD_BEEF));
    chk("dbeef_wr", 128'(obs[0].wr), 128'(5'd9));
    chk("dbeef_rw_v", 128'({obs[0].rw, obs[0].v}), 128'(2'b11));
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, 0, 0, 1, 32'(i), 0, 5'(i), "stream");
    chk("lat3_alu", 128'(obs[2].alu), 128'(32'd2));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
    step(0, 0, 1, 1, 0, 0, 1, 32'd7, 32'h77, 5'd7, "stall_load");
    for (int i = 0; i < 2; i++) begin
      rand_step(1, 0, "stall");
      chk("stall_alu", 128'(obs[0].alu), 128'(32'd7));
      chk("stall_v", 128'(obs[0].v), 128'(1'b1));
    end
    rand_step(0, 0, "stall_resume");
    step(0, 0, 1, 0, 0, 0, 1, 32'hB, 32'hB0, 5'd11, "coll_b");
    step(0, 0, 1, 0, 0, 1, 0, 32'hA, 32'hA0, 5'd10, "coll_a");
    rand_step(1, 1, "coll_both");
    chk("coll_hold_b", 128'({obs[1].v, obs[1].alu}), 128'({1'b1, 32'hB}));
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "coll_after");
    chk("coll_bubble", 128'({obs[1].v, obs[1].mw}), 128'(2'b00));
    step(0, 0, 0, 1, 1, 1, 1, 32'h1234, 32'h5678, 5'd3, "gate");
    chk("gate_ctrl", 128'({obs[0].v, obs[0].mw, obs[0].rw, obs_frw[0]}), 128'(0));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 1, $urandom, $urandom, 5'($urandom), "gate_lat");
    for (int i = 0; i < 400; i++) rand_step($urandom_range(3) == 0, $urandom_range(5) == 0, "rand");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 1, 1, $urandom, $urandom, 5'($urandom), "fill");
    #2 Rst_n = 1'b0;
    #1 clear_model();
    check_all("areset");
    @(negedge Clk);
    check_all("areset_edge");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
